// File: rtl/contador_campo_bcd_param.sv
// Two-digit BCD field counter for the clock/date setting path: manual stepping with press-and-hold
// auto-repeat, cascade increment from the lower field with carry, and validated parallel load.
//
//   state  | meaning
//   IDLE   | no button held; a fresh press steps once and starts the hold timer
//   HOLD   | button held, waiting HOLD_CYC cycles before auto-repeat begins
//   REPEAT | auto-repeat active, one step every RPT_CYC cycles while held
module contador_campo_bcd_param #(
   parameter int MIN_VAL  = 0,
   parameter int MAX_VAL  = 99,
   parameter int FIELD_ID = 4,
   parameter int HOLD_CYC = 50_000_000,
   parameter int RPT_CYC  = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] en_count,
   input  logic       enUP,
   input  logic       enDOWN,
   input  logic       inc_in,
   input  logic       load,
   input  logic [3:0] load_digit1,
   input  logic [3:0] load_digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic       carry_out
);

   localparam int TMAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
   localparam int TW   = $clog2(TMAX) + 1;
   localparam logic [TW-1:0] HOLD_TC = TW'(HOLD_CYC - 1);
   localparam logic [TW-1:0] RPT_TC  = TW'(RPT_CYC - 1);
   localparam logic [6:0]    MIN_C   = 7'(MIN_VAL);
   localparam logic [6:0]    MAX_C   = 7'(MAX_VAL);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [TW-1:0] timer, timer_nx;
   logic [6:0]    count, count_nx;
   logic          carry_nx;
   logic          sel, btn, step;
   logic [6:0]    up_val, dn_val, load_val;
   logic          load_ok, inc_ok;

   assign sel = (en_count == 4'(FIELD_ID));
   assign btn = sel & (enUP ^ enDOWN);

   assign up_val   = (count == MAX_C) ? MIN_C : count + 7'd1;
   assign dn_val   = (count == MIN_C) ? MAX_C : count - 7'd1;
   assign load_val = 7'(load_digit1) * 7'd10 + 7'(load_digit0);

   // Lower bound written as val+1 > MIN so MIN_VAL=0 does not collapse into a constant compare.
   assign load_ok = load
                  & (load_digit1 <= 4'd9) & (load_digit0 <= 4'd9)
                  & (load_val <= MAX_C)
                  & (({1'b0, load_val} + 8'd1) > 8'(MIN_VAL));

   assign inc_ok = inc_in & ~sel;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = timer;
      step     = 1'b0;
      case (state)
         IDLE: begin
            timer_nx = '0;
            if (btn) begin
               step     = 1'b1;
               state_nx = HOLD;
            end
         end
         HOLD: begin
            if (!btn) begin
               state_nx = IDLE;
               timer_nx = '0;
            end else if (timer == HOLD_TC) begin
               step     = 1'b1;
               timer_nx = '0;
               state_nx = REPEAT;
            end else begin
               timer_nx = timer + 1'b1;
            end
         end
         REPEAT: begin
            if (!btn) begin
               state_nx = IDLE;
               timer_nx = '0;
            end else if (timer == RPT_TC) begin
               step     = 1'b1;
               timer_nx = '0;
            end else begin
               timer_nx = timer + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            timer_nx = '0;
         end
      endcase
   end

   // Manual wraps never carry: fields are edited independently of one another.
   always_comb begin
      count_nx = count;
      carry_nx = 1'b0;
      if (load_ok) begin
         count_nx = load_val;
      end else if (step) begin
         count_nx = enUP ? up_val : dn_val;
      end else if (inc_ok) begin
         count_nx = up_val;
         carry_nx = (count == MAX_C);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= MIN_C;
         carry_out <= 1'b0;
      end else begin
         count     <= count_nx;
         carry_out <= carry_nx;
      end
   end

   assign digit1 = 4'(count / 7'd10);
   assign digit0 = 4'(count % 7'd10);

endmodule

// File: tb/tb_contador_campo_bcd_param.sv
// Self-checking bench for contador_campo_bcd_param with MIN=1, MAX=12, HOLD=8, RPT=4.
module tb_contador_campo_bcd_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] en_count;
   logic       enUP, enDOWN, inc_in, load;
   logic [3:0] load_digit1, load_digit0;
   logic [3:0] digit1, digit0;
   logic       carry_out;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] d1;
      logic [3:0] d0;
      logic       c;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   contador_campo_bcd_param #(
      .MIN_VAL(1), .MAX_VAL(12), .FIELD_ID(4), .HOLD_CYC(8), .RPT_CYC(4)
   ) dut (
      .clk(clk), .reset(rst_n), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
      .inc_in(inc_in), .load(load), .load_digit1(load_digit1), .load_digit0(load_digit0),
      .digit1(digit1), .digit0(digit0), .carry_out(carry_out)
   );

   always #5 clk = ~clk;

   function automatic void push(input int v, input bit c, input string n);
      exp_t x;
      x.d1 = 4'(v / 10);
      x.d0 = 4'(v % 10);
      x.c = c;
      x.name = n;
      sb.push_back(x);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en_count = 4'd0; enUP = 0; enDOWN = 0; inc_in = 0; load = 0;
      load_digit1 = 4'd0; load_digit0 = 4'd0;
   endtask

   task automatic do_load(input int d1, input int d0);
      load = 1; load_digit1 = 4'(d1); load_digit0 = 4'(d0);
      tick();
      load = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      #13;
      push(1, 0, "reset_asserted");
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
      tick();
      rst_n = 1;
      tick();
      push(1, 0, "reset_released");
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
   endtask

   task automatic test_hold_repeat();
      int model = 1;
      en_count = 4'd4; enUP = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 0 || i == 8 || i == 12 || i == 16) model = (model == 12) ? 1 : model + 1;
         push(model, 0, $sformatf("hold_edge%0d", i));
         tick();
         e = sb.pop_front(); checks++;
         if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
            errors++;
            $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
         end
      end
      enUP = 0;
      push(5, 0, "hold_release");
      tick();
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
      // an immediate step on the next press shows the FSM went back to IDLE
      enDOWN = 1;
      push(4, 0, "idle_after_release");
      tick();
      enDOWN = 0;
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
      tick();
   endtask

   task automatic test_down_wrap();
      en_count = 4'd3;
      do_load(0, 1);
      en_count = 4'd4; enDOWN = 1;
      push(12, 0, "down_wrap");
      tick();
      enDOWN = 0;
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
      tick();
      en_count = 4'd3; enDOWN = 1;
      push(12, 0, "down_unselected");
      tick(); tick();
      enDOWN = 0;
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
   endtask

   task automatic test_cascade();
      en_count = 4'd3; inc_in = 1;
      push(1, 1, "inc_wrap_carry");
      push(1, 0, "carry_one_cycle");
      tick();
      inc_in = 0;
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
      tick();
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
      do_load(0, 5);
      inc_in = 1;
      push(6, 0, "inc_no_wrap");
      tick();
      inc_in = 0;
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
      en_count = 4'd4; inc_in = 1;
      push(6, 0, "inc_blocked_when_sel");
      tick();
      inc_in = 0; en_count = 4'd3;
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
   endtask

   task automatic test_load();
      int vec[6][3] = '{'{0, 9, 9}, '{1, 3, 9}, '{0, 0, 9}, '{0, 12, 9}, '{1, 2, 12}, '{1, 0, 10}};
      en_count = 4'd3;
      foreach (vec[i]) begin
         push(vec[i][2], 0, $sformatf("load_%0d_%0d", vec[i][0], vec[i][1]));
         do_load(vec[i][0], vec[i][1]);
         e = sb.pop_front(); checks++;
         if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
            errors++;
            $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
         end
      end
      do_load(1, 2);
      inc_in = 1;
      push(7, 0, "load_beats_inc");
      do_load(0, 7);
      inc_in = 0;
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
   endtask

   task automatic test_both_buttons();
      en_count = 4'd4; enUP = 1; enDOWN = 1;
      for (int i = 0; i < 10; i++) begin
         push(7, 0, $sformatf("both_buttons%0d", i));
         tick();
         e = sb.pop_front(); checks++;
         if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
            errors++;
            $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
         end
      end
      enUP = 0; enDOWN = 0;
      tick();
   endtask

   task automatic test_reset_in_hold();
      en_count = 4'd3;
      do_load(0, 3);
      en_count = 4'd4; enUP = 1;
      tick(); tick(); tick();
      push(4, 0, "hold_before_reset");
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
      rst_n = 0;
      #1;
      push(1, 0, "reset_in_hold");
      e = sb.pop_front(); checks++;
      if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
         errors++;
         $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
      end
      tick();
      rst_n = 1;
      // still-held button is a fresh press: one step now, then a full hold period before the next
      for (int i = 0; i < 8; i++) begin
         push(2, 0, $sformatf("fresh_press_edge%0d", i));
         tick();
         e = sb.pop_front(); checks++;
         if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
            errors++;
            $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
         end
      end
      enUP = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      int exp_v[4] = '{11, 12, 1, 2};
      bit exp_c[4] = '{0, 0, 1, 0};
      en_count = 4'd3;
      do_load(1, 0);
      inc_in = 1;
      for (int i = 0; i < 4; i++) begin
         push(exp_v[i], exp_c[i], $sformatf("b2b_inc%0d", i));
         tick();
         e = sb.pop_front(); checks++;
         if ({digit1, digit0, carry_out} !== {e.d1, e.d0, e.c}) begin
            errors++;
            $display("FAIL %s: got %0d%0d c=%0b expected %0d%0d c=%0b", e.name, digit1, digit0, carry_out, e.d1, e.d0, e.c);
         end
      end
      inc_in = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_hold_repeat();
      test_down_wrap();
      test_cascade();
      test_load();
      test_both_buttons();
      test_reset_in_hold();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
